// File: rtl/portgroup_rx_capture.sv
// Pair-assembling capture stage feeding the portgroup RX register interface.
// Two consecutive stream words are presented together on data0_o/data1_o.
module portgroup_rx_capture #(
    parameter int width_p    = 8,
    parameter int cntwidth_p = 4
) (
    input  logic                  main_clk_i,
    input  logic                  main_rst_an_i,
    input  logic                  ctrl_ena_i,
    input  logic                  rx_valid_i,
    output logic                  rx_ready_o,
    input  logic [width_p-1:0]    rx_data_i,
    output logic [width_p-1:0]    data0_o,
    output logic [width_p-1:0]    data1_o,
    output logic                  pair_vld_o,
    input  logic                  pair_ack_i,
    output logic                  ovf_o,
    input  logic                  ovf_clr_i,
    output logic [cntwidth_p-1:0] frame_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        FULL = 2'd3
    } state_t;

    localparam logic [cntwidth_p-1:0] cnt_one = 1;

    state_t                  state_q;
    logic [width_p-1:0]      stage_q;
    logic [width_p-1:0]      data0_q;
    logic [width_p-1:0]      data1_q;
    logic                    pair_vld_q;
    logic                    ovf_q;
    logic [cntwidth_p-1:0]   cnt_q;
    logic                    xfer;

    assign rx_ready_o  = (state_q != IDLE);
    assign xfer        = rx_valid_i & rx_ready_o;
    assign data0_o     = data0_q;
    assign data1_o     = data1_q;
    assign pair_vld_o  = pair_vld_q;
    assign ovf_o       = ovf_q;
    assign frame_cnt_o = cnt_q;

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            state_q    <= IDLE;
            stage_q    <= '0;
            data0_q    <= '0;
            data1_q    <= '0;
            pair_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            // The overflow set below is assigned later, so it beats a same-edge clear.
            if (ovf_clr_i) begin
                ovf_q <= 1'b0;
            end
            if (!ctrl_ena_i) begin
                state_q    <= IDLE;
                pair_vld_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: state_q <= LO;
                    LO: begin
                        if (xfer) begin
                            stage_q <= rx_data_i;
                            state_q <= HI;
                        end
                    end
                    HI: begin
                        if (xfer) begin
                            data0_q    <= stage_q;
                            data1_q    <= rx_data_i;
                            pair_vld_q <= 1'b1;
                            cnt_q      <= cnt_q + cnt_one;
                            state_q    <= FULL;
                        end
                    end
                    FULL: begin
                        if (pair_ack_i) begin
                            pair_vld_q <= 1'b0;
                            if (xfer) begin
                                stage_q <= rx_data_i;
                                state_q <= HI;
                            end else begin
                                state_q <= LO;
                            end
                        end else if (xfer) begin
                            ovf_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
